// File: rtl/hilo_md_ctrl.sv
// HI/LO sequencer: iterative 32-step shift-add MULT/MULTU and restoring DIV/DIVU, stalling EX while busy.
// Optional macro HILO_FAST_MUL_EN sends multiplies through a single-cycle multiplier instead.
module hilo_md_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             hi_we_o,
  output logic             lo_we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic               mul_q, neg_q, rsign_q, we_q;
  logic [WIDTH-1:0]   a_q, b_q, d_q, hi_q, lo_q;

  logic               accept, is_mul, sgn, div0, fast, s1, s2, last;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     rem_w, mac;
  logic [WIDTH-1:0]   rem_sub, a_n, b_n;
  logic [WIDTH-1:0]   hi_fix, lo_fix;
  logic [2*WIDTH-1:0] prod_abs, prod_fix, fast_prod;

  assign is_mul = op_i[1];
  assign sgn    = ~op_i[0];
  assign s1     = sgn & src1_i[WIDTH-1];
  assign s2     = sgn & src2_i[WIDTH-1];
  assign abs1   = s1 ? -src1_i : src1_i;
  assign abs2   = s2 ? -src2_i : src2_i;
  assign div0   = ~is_mul & (src2_i == '0);
  assign accept = (state_q == IDLE) & start_i & ~flush_i;
  assign last   = (cnt_q == CW'(WIDTH-1));

`ifdef HILO_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_mag;
  assign fast      = is_mul;
  assign fast_mag  = {{WIDTH{1'b0}}, abs1} * {{WIDTH{1'b0}}, abs2};
  assign fast_prod = (s1 ^ s2) ? -fast_mag : fast_mag;
`else
  assign fast      = 1'b0;
  assign fast_prod = '0;
`endif

  // One iteration: a_q is remainder / product-high, b_q is quotient / multiplier-low
  always_comb begin
    rem_w   = {a_q, b_q[WIDTH-1]};
    rem_sub = rem_w[WIDTH-1:0] - d_q;
    mac     = {1'b0, a_q} + (b_q[0] ? {1'b0, d_q} : '0);
    a_n     = rem_w[WIDTH-1:0];
    b_n     = {b_q[WIDTH-2:0], 1'b0};
    if (mul_q) begin
      a_n = mac[WIDTH:1];
      b_n = {mac[0], b_q[WIDTH-1:1]};
    end else if (rem_w >= {1'b0, d_q}) begin
      a_n = rem_sub;
      b_n = {b_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    prod_abs = {a_n, b_n};
    prod_fix = neg_q ? -prod_abs : prod_abs;
    if (mul_q) begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end else begin
      hi_fix = rsign_q ? -a_n : a_n;
      lo_fix = neg_q ? -b_n : b_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (div0 | fast) ? DONE : CALC;
      CALC: if (flush_i) state_d = IDLE;
            else if (last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_o = accept | (state_q == CALC);
    busy_o  = (state_q != IDLE);
    hi_we_o = we_q & (state_q == DONE) & ~flush_i;
    lo_we_o = we_q & (state_q == DONE) & ~flush_i;
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  // Result registers default to zero so they only carry data during DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      rsign_q <= 1'b0;
      we_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      we_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      case (state_q)
        IDLE: if (accept) begin
          cnt_q   <= '0;
          mul_q   <= is_mul;
          neg_q   <= s1 ^ s2;
          rsign_q <= s1;
          a_q     <= '0;
          b_q     <= is_mul ? abs2 : abs1;
          d_q     <= is_mul ? abs1 : abs2;
          if (div0) begin
            we_q <= 1'b1;
            hi_q <= src1_i;
            lo_q <= '1;
          end else if (fast) begin
            we_q <= 1'b1;
            hi_q <= fast_prod[2*WIDTH-1:WIDTH];
            lo_q <= fast_prod[WIDTH-1:0];
          end
        end
        CALC: if (!flush_i) begin
          a_q   <= a_n;
          b_q   <= b_n;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            we_q <= 1'b1;
            hi_q <= hi_fix;
            lo_q <= lo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Randomized and directed bench for hilo_md_ctrl against an arithmetic reference model.
module tb_hilo_md_ctrl;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, flush_i;
  logic [1:0]    op_i;
  logic [W-1:0]  src1_i, src2_i;
  logic          stall_o, busy_o, hi_we_o, lo_we_o;
  logic [W-1:0]  hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  hilo_md_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .hi_we_o(hi_we_o), .lo_we_o(lo_we_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Signed ops use longint arithmetic (truncating division, remainder follows dividend)
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
    longint     sa, sb, q, r;
    logic [63:0] ua, ub, p;
    if (op[0] == 1'b0) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    if (op[1]) begin
      ua = sa;
      ub = sb;
      p  = ua * ub;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  function automatic int exp_stalls(input logic [1:0] op, input logic [31:0] b);
    if (!op[1] && b == 32'd0) return 1;
`ifdef HILO_FAST_MUL_EN
    if (op[1]) return 1;
`endif
    return W + 1;
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after the write
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ehi, elo;
    int stalls, wcyc;
    bit seen, leak;
    ref_model(op, a, b, ehi, elo);
    start_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
    stalls = 0; seen = 0; leak = 0; wcyc = -1;
    for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
      #1;
      if (stall_o) stalls++;
      if (hi_we_o) begin
        seen = 1;
        wcyc = cyc;
        check({tag, ".hi"}, {32'b0, hi_o}, {32'b0, ehi});
        check({tag, ".lo"}, {32'b0, lo_o}, {32'b0, elo});
        check({tag, ".lo_we"}, {63'b0, lo_we_o}, 64'd1);
      end else if (hi_o != '0 || lo_o != '0 || lo_we_o) begin
        leak = 1;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    check({tag, ".write_seen"}, {63'b0, seen}, 64'd1);
    check({tag, ".write_cycle"}, 64'(wcyc), 64'(exp_stalls(op, b)));
    check({tag, ".stalls"}, 64'(stalls), 64'(exp_stalls(op, b)));
    check({tag, ".no_leak"}, {63'b0, leak}, 64'd0);
    #1;
    check({tag, ".idle_after"}, {63'b0, busy_o}, 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bit any_we;

    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 2'b00; src1_i = '0; src2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy",  {63'b0, busy_o},  64'd0);
    check("rst.stall", {63'b0, stall_o}, 64'd0);
    check("rst.we",    {62'b0, hi_we_o, lo_we_o}, 64'd0);
    check("rst.hilo",  {hi_o, lo_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op("divu_100_7",  2'b01, 32'd100, 32'd7);
    do_op("div_m7_2",    2'b00, 32'hFFFF_FFF9, 32'd2);
    do_op("div_min_m1",  2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("mult_m1_3",   2'b10, 32'hFFFF_FFFF, 32'd3);
    do_op("multu_m1_3",  2'b11, 32'hFFFF_FFFF, 32'd3);
    do_op("divu_5_0",    2'b01, 32'd5, 32'd0);
    do_op("div_m9_0",    2'b00, 32'hFFFF_FFF7, 32'd0);
    do_op("multu_64k",   2'b11, 32'h0001_0000, 32'h0001_0000);
    do_op("div_7_m2",    2'b00, 32'd7, 32'hFFFF_FFFE);

    // flush blocks acceptance in IDLE
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; src1_i = 32'd9; src2_i = 32'd3;
    #1 check("flush_idle.stall", {63'b0, stall_o}, 64'd0);
    @(negedge clk);
    #1 check("flush_idle.busy", {63'b0, busy_o}, 64'd0);
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);

    // flush at cycle 10 of a DIVU: no write, idle by cycle 11
    start_i = 1'b1; op_i = 2'b01; src1_i = 32'd1000; src2_i = 32'd3;
    repeat (10) @(negedge clk);
    flush_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    #1 check("flush_calc.busy", {63'b0, busy_o}, 64'd0);
    any_we = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (hi_we_o || lo_we_o) any_we = 1;
    end
    check("flush_calc.no_we", {63'b0, any_we}, 64'd0);

    // flush during DONE suppresses the write enables
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; src1_i = 32'd5; src2_i = 32'd0;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b1;
    #1;
    check("flush_done.busy", {63'b0, busy_o}, 64'd1);
    check("flush_done.we", {62'b0, hi_we_o, lo_we_o}, 64'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1 check("flush_done.idle", {63'b0, busy_o}, 64'd0);

    // rst at cycle 12 of a second op
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b11; src1_i = 32'd12345; src2_i = 32'd678;
    repeat (12) @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid.busy",  {63'b0, busy_o},  64'd0);
    check("rst_mid.stall", {63'b0, stall_o}, 64'd0);
    check("rst_mid.we",    {62'b0, hi_we_o, lo_we_o}, 64'd0);
    check("rst_mid.hilo",  {hi_o, lo_o}, 64'd0);
    rst = 1'b0;
    any_we = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (hi_we_o || lo_we_o) any_we = 1;
    end
    check("rst_mid.no_we", {63'b0, any_we}, 64'd0);
    @(negedge clk);

    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      do_op($sformatf("rand%0d", n), rop, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
